// File: rtl/scan_chain_controller.sv
// Scan chain swap sequencer for the memory bank.
// Bytes from the host are shifted into the chain LSB first, while the
// bits falling off the chain tail are packed into bytes for the host.
// The chain only moves in SHIFT, so a stall on either stream freezes it.
module scan_chain_controller #(
  parameter int CHAIN_LEN = 256,
  parameter int CNT_WIDTH = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       abort_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       cpu_stall_o,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       scan_enable_o,
  output logic       scan_in_o,
  input  logic       scan_out_i
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    EMIT,
    FIN
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] bits_left_q, bits_left_d;
  logic [3:0]           k_q, k_d;
  logic [2:0]           idx_q, idx_d;
  logic [7:0]           in_sh_q, in_sh_d;
  logic [7:0]           out_sh_q, out_sh_d;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bits_left_q <= '0;
      k_q         <= '0;
      idx_q       <= '0;
      in_sh_q     <= '0;
      out_sh_q    <= '0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      k_q         <= k_d;
      idx_q       <= idx_d;
      in_sh_q     <= in_sh_d;
      out_sh_q    <= out_sh_d;
    end
  end

  // Next state and datapath updates; abort overrides every transition
  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    k_d         = k_q;
    idx_d       = idx_q;
    in_sh_d     = in_sh_q;
    out_sh_d    = out_sh_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = LOAD;
          bits_left_d = CNT_WIDTH'(CHAIN_LEN);
        end
      end
      LOAD: begin
        if (in_valid_i) begin
          in_sh_d  = in_data_i;
          out_sh_d = '0;
          idx_d    = '0;
          k_d      = (bits_left_q >= CNT_WIDTH'(8)) ? 4'd8 : 4'(bits_left_q);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        out_sh_d[idx_q] = scan_out_i;
        in_sh_d         = {1'b0, in_sh_q[7:1]};
        bits_left_d     = bits_left_q - CNT_WIDTH'(1);
        idx_d           = idx_q + 3'd1;
        if ({1'b0, idx_q} == (k_q - 4'd1)) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready_i) begin
          state_d = (bits_left_q != '0) ? LOAD : FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort_i) begin
      state_d = IDLE;
    end
  end

  // Outputs decoded purely from the current state
  always_comb begin
    busy_o        = (state_q != IDLE);
    cpu_stall_o   = (state_q != IDLE);
    done_o        = (state_q == FIN);
    in_ready_o    = (state_q == LOAD);
    out_valid_o   = (state_q == EMIT);
    scan_enable_o = (state_q == SHIFT);
    scan_in_o     = (state_q == SHIFT) && in_sh_q[0];
    out_data_o    = out_sh_q;
  end

endmodule
